// File: rtl/seven_segment_mux_if.sv
// CPU-side register bus and board-pin outputs of the seven-segment scan driver.
interface seven_segment_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      lz_blank;
  logic                      enable;
  logic [6:0]                segments;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     digit_sel;
  logic                      pending;

  modport master (
    output load, value, dp_in, lz_blank, enable,
    input  segments, dp, digit_sel, pending
  );

  modport slave (
    input  load, value, dp_in, lz_blank, enable,
    output segments, dp, digit_sel, pending
  );
endinterface

// File: rtl/seven_segment_mux.sv
// Time-multiplexed hex seven-segment driver: double-buffered value, prescaled digit scan,
// leading-zero suppression and a blank cycle after every slot change to stop ghosting.
module seven_segment_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input logic                clk,
  input logic                reset,
  seven_segment_mux_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Off levels double as XOR masks that convert active-high patterns to pin polarity.
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_value, disp_value;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                    pending_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   sel_q;

  logic                    tick, frame_tick, show;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, blank_chain;
  logic [NUM_DIGITS-1:0]   sel_on;
  logic [6:0]              seg_next;
  logic                    dp_next;

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    case (nib)
      4'h0:    decode_hex = 7'h3F;
      4'h1:    decode_hex = 7'h06;
      4'h2:    decode_hex = 7'h5B;
      4'h3:    decode_hex = 7'h4F;
      4'h4:    decode_hex = 7'h66;
      4'h5:    decode_hex = 7'h6D;
      4'h6:    decode_hex = 7'h7D;
      4'h7:    decode_hex = 7'h07;
      4'h8:    decode_hex = 7'h7F;
      4'h9:    decode_hex = 7'h6F;
      4'hA:    decode_hex = 7'h77;
      4'hB:    decode_hex = 7'h7C;
      4'hC:    decode_hex = 7'h39;
      4'hD:    decode_hex = 7'h5E;
      4'hE:    decode_hex = 7'h79;
      default: decode_hex = 7'h71;
    endcase
  endfunction

  assign tick       = (cnt == CNT_LAST);
  assign frame_tick = tick && (idx == IDX_LAST);
  assign show       = bus.enable && !tick;

  // NOTE: every variable gets a default before the loop so no path can infer a latch.
  always_comb begin
    cur_nib     = '0;
    cur_dp      = 1'b0;
    cur_blank   = 1'b0;
    sel_on      = '0;
    blank_chain = bus.lz_blank;
    // Walk from the most significant digit down; a zero stays blank only below blank digits.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      blank_chain = blank_chain && (disp_value[4*i +: 4] == 4'h0) && !disp_dp[i] && (i != 0);
      if (idx == IDX_W'(i)) begin
        cur_nib   = disp_value[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = blank_chain;
        sel_on[i] = 1'b1;
      end
    end
    seg_next = cur_blank ? 7'h00 : decode_hex(cur_nib);
    dp_next  = cur_dp && !cur_blank;
  end

  // NOTE: non-blocking assignments so every register samples the same pre-edge state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      sel_q        <= SEL_OFF;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= frame_tick ? '0 : idx + 1'b1;

      // A load landing on the frame tick bypasses the shadow wait entirely.
      if (bus.load && frame_tick) begin
        shadow_value <= bus.value;
        shadow_dp    <= bus.dp_in;
        disp_value   <= bus.value;
        disp_dp      <= bus.dp_in;
        pending_q    <= 1'b0;
      end else if (bus.load) begin
        shadow_value <= bus.value;
        shadow_dp    <= bus.dp_in;
        pending_q    <= 1'b1;
      end else if (frame_tick && pending_q) begin
        disp_value   <= shadow_value;
        disp_dp      <= shadow_dp;
        pending_q    <= 1'b0;
      end

      seg_q <= show ? (seg_next ^ SEG_OFF) : SEG_OFF;
      dp_q  <= show ? (dp_next ^ DP_OFF)   : DP_OFF;
      sel_q <= show ? (sel_on ^ SEL_OFF)   : SEL_OFF;
    end
  end

  assign bus.segments  = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_sel = sel_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux with 4 digits, CLK_DIV=4, active-low pins;
// one frame is 16 cycles, tracked by a bench-side cycle counter from reset release.
module tb_seven_segment_mux;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc;

  seven_segment_mux_if #(.NUM_DIGITS(4)) bus ();

  seven_segment_mux #(
    .NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; after edge t the slot is (t-1)%4 and digit ((t-1)/4)%4.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [6:0] seg, input logic [3:0] sel,
                           input logic dpv);
    check({tag, ".seg"}, {25'b0, bus.segments}, {25'b0, seg});
    check({tag, ".sel"}, {28'b0, bus.digit_sel}, {28'b0, sel});
    check({tag, ".dp"},  {31'b0, bus.dp}, {31'b0, dpv});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int p);
    while ((cyc % 16) != p) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp_in = d;
    step(1);
    bus.load  = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.lz_blank = 1'b0;
    bus.enable   = 1'b1;

    // 1. Reset and the first slots of an all-zero display.
    step(3);
    check_out("reset", 7'h7F, 4'hF, 1'b1);
    check("reset.pending", {31'b0, bus.pending}, 32'd0);
    reset = 1'b0;
    check_out("post_release", 7'h7F, 4'hF, 1'b1);
    step(1);
    check_out("first_slot_d0", 7'h40, 4'hE, 1'b1);
    step(3);
    check_out("first_ghost", 7'h7F, 4'hF, 1'b1);
    step(1);
    check_out("first_slot_d1", 7'h40, 4'hD, 1'b1);

    // 2. Buffered load of A,b,3,d shows only after the frame tick.
    wait_phase(2);
    do_load(16'hAB3D, 4'b0000);
    check("ab3d.pending_set", {31'b0, bus.pending}, 32'd1);
    wait_phase(15);
    check("ab3d.pending_hold", {31'b0, bus.pending}, 32'd1);
    step(1);
    check("ab3d.pending_clr", {31'b0, bus.pending}, 32'd0);
    check("ab3d.ghost_sel", {28'b0, bus.digit_sel}, 32'hF);
    step(1);
    check_out("ab3d.d0", 7'h21, 4'hE, 1'b1);
    step(4);
    check_out("ab3d.d1", 7'h30, 4'hD, 1'b1);
    step(4);
    check_out("ab3d.d2", 7'h03, 4'hB, 1'b1);
    step(4);
    check_out("ab3d.d3", 7'h08, 4'h7, 1'b1);

    // Whole-frame scan pattern, including the blank cycle after every tick.
    wait_phase(0);
    for (int k = 0; k < 16; k++) begin
      int slot, dig;
      logic [3:0] exp_sel;
      step(1);
      slot = (cyc - 1) % 4;
      dig  = ((cyc - 1) / 4) % 4;
      exp_sel = (slot == 3) ? 4'hF : ~(4'b0001 << dig);
      check("scan.sel", {28'b0, bus.digit_sel}, {28'b0, exp_sel});
    end

    // 3. Two loads before transfer: last one wins.
    wait_phase(1);
    do_load(16'h1234, 4'b0000);
    check("lww.pending1", {31'b0, bus.pending}, 32'd1);
    wait_phase(4);
    do_load(16'h5678, 4'b0000);
    check("lww.pending2", {31'b0, bus.pending}, 32'd1);
    step(1);
    check_out("lww.old_d1", 7'h30, 4'hD, 1'b1);
    wait_phase(0);
    check("lww.pending_clr", {31'b0, bus.pending}, 32'd0);
    step(1);
    check_out("lww.d0", 7'h00, 4'hE, 1'b1);
    step(4);
    check_out("lww.d1", 7'h78, 4'hD, 1'b1);
    step(4);
    check_out("lww.d2", 7'h02, 4'hB, 1'b1);
    step(4);
    check_out("lww.d3", 7'h12, 4'h7, 1'b1);

    // 4. Leading-zero suppression, then a decimal point stops it.
    bus.lz_blank = 1'b1;
    wait_phase(2);
    do_load(16'h0070, 4'b0000);
    wait_phase(0);
    step(1);
    check_out("lz.d0", 7'h40, 4'hE, 1'b1);
    step(4);
    check_out("lz.d1", 7'h78, 4'hD, 1'b1);
    step(4);
    check_out("lz.d2", 7'h7F, 4'hB, 1'b1);
    step(4);
    check_out("lz.d3", 7'h7F, 4'h7, 1'b1);
    wait_phase(2);
    do_load(16'h0070, 4'b0100);
    wait_phase(0);
    step(9);
    check_out("lzdp.d2", 7'h40, 4'hB, 1'b0);
    step(4);
    check_out("lzdp.d3", 7'h7F, 4'h7, 1'b1);

    // 5. Load on the frame tick goes straight to the display.
    wait_phase(15);
    do_load(16'hCE01, 4'b0001);
    check("ft.pending_tick", {31'b0, bus.pending}, 32'd0);
    check("ft.ghost_sel", {28'b0, bus.digit_sel}, 32'hF);
    step(1);
    check("ft.pending_next", {31'b0, bus.pending}, 32'd0);
    check_out("ft.d0", 7'h79, 4'hE, 1'b0);
    step(4);
    check_out("ft.d1_inner_zero", 7'h40, 4'hD, 1'b1);
    step(4);
    check_out("ft.d2", 7'h06, 4'hB, 1'b1);
    step(4);
    check_out("ft.d3", 7'h46, 4'h7, 1'b1);

    // 6. enable=0 darkens the display while the scan keeps running.
    wait_phase(3);
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check_out("dis", 7'h7F, 4'hF, 1'b1);
    end
    bus.enable = 1'b1;
    step(1);
    check_out("reen.d3_s1", 7'h46, 4'h7, 1'b1);
    step(1);
    check_out("reen.d3_s2", 7'h46, 4'h7, 1'b1);

    // 7. Reset while a load is pending discards it.
    wait_phase(2);
    do_load(16'h9999, 4'b1111);
    check("rst.pending_set", {31'b0, bus.pending}, 32'd1);
    reset = 1'b1;
    step(1);
    check("rst.pending_clr", {31'b0, bus.pending}, 32'd0);
    check_out("rst.dark", 7'h7F, 4'hF, 1'b1);
    reset = 1'b0;
    step(1);
    check_out("rst.d0", 7'h40, 4'hE, 1'b1);
    wait_phase(0);
    step(5);
    check_out("rst.d1_blank", 7'h7F, 4'hD, 1'b1);
    check("rst.pending_after", {31'b0, bus.pending}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
